// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button conditioning blocks.
package debounce_pkg;

  // Debounce FSM state encoding.
  localparam logic [1:0] S_LOW       = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW  = 2'd3;

  typedef enum logic [1:0] {
    ST_LOW       = S_LOW,
    ST_WAIT_HIGH = S_WAIT_HIGH,
    ST_HIGH      = S_HIGH,
    ST_WAIT_LOW  = S_WAIT_LOW
  } deb_state_e;

  // 10 ms of stability at a 100 MHz system clock.
  localparam int unsigned STABLE_CYCLES_100MHZ = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs (buttons, switches).
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic sync1_q;
  logic sync2_q;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizer, stability counter and debounce FSM
// producing a clean level plus single-cycle rise/fall pulses.
//
// state       | meaning
// ------------+---------------------------------------------------------
// LOW         | accepted level 0, input agrees
// WAIT_HIGH   | level 0, input high; counting consecutive high samples
// HIGH        | accepted level 1, input agrees
// WAIT_LOW    | level 1, input low; counting consecutive low samples
module btn_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_100MHZ,
  parameter int unsigned CNT_W         = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             btn_sync;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_in),
    .q       (btn_sync)
  );

  // Next-state logic: a new level is accepted only after STABLE_CYCLES
  // consecutive disagreeing samples; the counter stops at the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (btn_sync) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!btn_sync) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = ST_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!btn_sync) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (btn_sync) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = ST_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and output registers; reset discards any partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule
